// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: two writeback FIFOs, round-robin arbitrated onto the
// single register-file write port through a registered output stage.
module regfile_write_arbiter #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [4:0]       req0_reg,
    input  logic [31:0]      req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [4:0]       req1_reg,
    input  logic [31:0]      req1_data,
    output logic             req1_ready,
    output logic [4:0]       write_reg,
    output logic [31:0]      write_data,
    output logic             reg_write,
    output logic [31:0]      pending_mask,
    output logic [CNT_W-1:0] write_count
);
    localparam int AW = $clog2(DEPTH);

    logic [4:0]  f_reg  [2][DEPTH];
    logic [31:0] f_data [2][DEPTH];
    logic [AW-1:0] rd [2];
    logic [AW-1:0] wr [2];
    logic [AW:0]   cnt [2];
    logic [4:0]  in_reg [2];
    logic [31:0] in_data [2];
    logic [4:0]  head_reg [2];
    logic [31:0] head_data [2];
    logic [1:0] in_valid, ready, avail, push, grant, store, adv;
    logic last_grant, sel, pop, wen;

    assign req0_ready = ready[0];
    assign req1_ready = ready[1];

    always_comb begin
        in_valid = {req1_valid, req0_valid};
        in_reg = '{req0_reg, req1_reg};
        in_data = '{req0_data, req1_data};
        ready = '0;
        avail = '0;
        push = '0;
        grant = '0;
        store = '0;
        adv = '0;
        for (int i = 0; i < 2; i++) begin
            ready[i] = cnt[i] < (AW+1)'(DEPTH);
            avail[i] = cnt[i] != '0 || in_valid[i];
            push[i] = in_valid[i] && ready[i];
            // An empty FIFO presents its incoming entry so it can reach the port at the push edge.
            head_reg[i] = cnt[i] != '0 ? f_reg[i][rd[i]] : in_reg[i];
            head_data[i] = cnt[i] != '0 ? f_data[i][rd[i]] : in_data[i];
        end
        pop = |avail;
        sel = &avail ? ~last_grant : avail[1];
        wen = pop && head_reg[sel] != '0;
        for (int i = 0; i < 2; i++) begin
            grant[i] = pop && sel == 1'(i);
            store[i] = push[i] && !(cnt[i] == '0 && grant[i]);
            adv[i] = grant[i] && cnt[i] != '0;
        end
        pending_mask = reg_write ? 32'(1) << write_reg : '0;
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < DEPTH; j++)
                if ((AW+1)'(j) < cnt[i])
                    pending_mask[f_reg[i][rd[i] + AW'(j)]] = 1'b1;
        pending_mask[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (store[i]) begin
                f_reg[i][wr[i]] <= in_reg[i];
                f_data[i][wr[i]] <= in_data[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                rd[i] <= '0;
                wr[i] <= '0;
                cnt[i] <= '0;
            end
            last_grant <= 1'b1;
            reg_write <= 1'b0;
            write_reg <= '0;
            write_data <= '0;
            write_count <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (store[i]) wr[i] <= wr[i] + 1'b1;
                if (adv[i]) rd[i] <= rd[i] + 1'b1;
                cnt[i] <= cnt[i] + (AW+1)'(store[i]) - (AW+1)'(adv[i]);
            end
            if (pop) begin
                last_grant <= sel;
                write_reg <= head_reg[sel];
                write_data <= head_data[sel];
            end
            reg_write <= wen;
            if (wen) write_count <= write_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_regfile_write_arbiter;
    localparam int DEPTH = 2;

    typedef struct {
        logic [4:0]  r;
        logic [31:0] d;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic req0_valid = 1'b0, req1_valid = 1'b0;
    logic [4:0] req0_reg = '0, req1_reg = '0;
    logic [31:0] req0_data = '0, req1_data = '0;
    logic req0_ready, req1_ready, reg_write;
    logic [4:0] write_reg;
    logic [31:0] write_data, pending_mask;
    logic [15:0] write_count;
    logic w_ready0, w_ready1, w_reg_write;
    logic [4:0] w_write_reg;
    logic [31:0] w_write_data, w_mask;
    logic [3:0] w_count;

    int n_cmp = 0;
    int n_fail = 0;
    ent_t s0[$], s1[$];
    ent_t mq0[$], mq1[$];
    int log_q[$];
    bit saw_full;
    logic exp_we = 1'b0;
    logic [4:0] exp_reg = '0;
    logic [31:0] exp_data = '0;
    int exp_cnt = 0;
    int mlast = 1;

    always #5 clk = ~clk;

    regfile_write_arbiter #(.DEPTH(DEPTH), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_reg(req0_reg), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_reg(req1_reg), .req1_data(req1_data), .req1_ready(req1_ready),
        .write_reg(write_reg), .write_data(write_data), .reg_write(reg_write),
        .pending_mask(pending_mask), .write_count(write_count)
    );

    regfile_write_arbiter #(.DEPTH(DEPTH), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_reg(req0_reg), .req0_data(req0_data), .req0_ready(w_ready0),
        .req1_valid(req1_valid), .req1_reg(req1_reg), .req1_data(req1_data), .req1_ready(w_ready1),
        .write_reg(w_write_reg), .write_data(w_write_data), .reg_write(w_reg_write),
        .pending_mask(w_mask), .write_count(w_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_mask();
        logic [31:0] m = '0;
        foreach (mq0[i]) m[mq0[i].r] = 1'b1;
        foreach (mq1[i]) m[mq1[i].r] = 1'b1;
        if (exp_we) m[exp_reg] = 1'b1;
        m[0] = 1'b0;
        return m;
    endfunction

    // Reference: accept pushes into queues, then pop one front by round-robin.
    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            mq0.delete();
            mq1.delete();
            exp_we = 1'b0;
            exp_reg = '0;
            exp_data = '0;
            exp_cnt = 0;
            mlast = 1;
        end else begin
            ent_t e;
            int g;
            bit r0, r1;
            r0 = mq0.size() < DEPTH;
            r1 = mq1.size() < DEPTH;
            if (req0_valid && r0) mq0.push_back('{req0_reg, req0_data});
            if (req1_valid && r1) mq1.push_back('{req1_reg, req1_data});
            g = (mq0.size() > 0 && mq1.size() > 0) ? 1 - mlast :
                mq0.size() > 0 ? 0 : mq1.size() > 0 ? 1 : -1;
            if (g < 0) exp_we = 1'b0;
            else begin
                e = (g == 0) ? mq0.pop_front() : mq1.pop_front();
                exp_reg = e.r;
                exp_data = e.d;
                exp_we = e.r != 0;
                if (exp_we) exp_cnt++;
                mlast = g;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        chk("reg_write", reg_write, exp_we);
        chk("write_reg", write_reg, exp_reg);
        chk("write_data", write_data, exp_data);
        chk("write_count", write_count, 32'(exp_cnt % 65536));
        chk("pending_mask", pending_mask, exp_mask());
        chk("req0_ready", req0_ready, mq0.size() < DEPTH);
        chk("req1_ready", req1_ready, mq1.size() < DEPTH);
        chk("w4_reg_write", w_reg_write, exp_we);
        chk("w4_write_count", w_count, 32'(exp_cnt % 16));
        if (reg_write) log_q.push_back(int'(write_reg));
    end

    task automatic run();
        int cyc = 0;
        logic a0, a1;
        while ((s0.size() > 0 || s1.size() > 0) && cyc < 200) begin
            @(negedge clk);
            req0_valid = s0.size() > 0;
            req1_valid = s1.size() > 0;
            if (req0_valid) begin req0_reg = s0[0].r; req0_data = s0[0].d; end
            if (req1_valid) begin req1_reg = s1[0].r; req1_data = s1[0].d; end
            if (req1_valid && !req1_ready) saw_full = 1'b1;
            a0 = req0_valid && req0_ready;
            a1 = req1_valid && req1_ready;
            @(posedge clk);
            if (a0) void'(s0.pop_front());
            if (a1) void'(s1.pop_front());
            cyc++;
        end
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        if (cyc >= 200) begin
            n_cmp++;
            n_fail++;
            $display("FAIL run_timeout: got %0d cycles expected < 200", cyc);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        log_q.delete();
    endtask

    initial begin
        int got[$];
        int exp_c[6] = '{2, 30, 3, 29, 4, 28};
        @(negedge clk);
        chk("rst_reg_write", reg_write, 0);
        chk("rst_count", write_count, 0);
        chk("rst_mask", pending_mask, 0);
        chk("rst_ready0", req0_ready, 1);
        chk("rst_ready1", req1_ready, 1);
        rst = 1'b0;

        @(negedge clk);
        req0_valid = 1'b1; req0_reg = 5'd1; req0_data = 32'h0000FFFF;
        @(negedge clk);
        req0_valid = 1'b0;
        chk("single_we", reg_write, 1);
        chk("single_reg", write_reg, 1);
        chk("single_data", write_data, 32'h0000FFFF);
        chk("single_mask", pending_mask, 32'h2);
        chk("single_count", write_count, 1);
        @(negedge clk);
        chk("single_mask_clear", pending_mask, 0);
        chk("single_we_drop", reg_write, 0);

        do_reset();
        for (int k = 0; k < 3; k++) begin
            s0.push_back('{5'(2 + k), 32'h100 + 32'(k)});
            s1.push_back('{5'(30 - k), 32'h200 + 32'(k)});
        end
        run();
        repeat (4) @(negedge clk);
        chk("conflict_len", log_q.size(), 6);
        for (int k = 0; k < 6 && k < log_q.size(); k++) chk($sformatf("conflict_order%0d", k), log_q[k], exp_c[k]);
        chk("conflict_count", write_count, 6);

        log_q.delete();
        saw_full = 1'b0;
        for (int k = 0; k < 6; k++) s0.push_back('{5'(5 + k), 32'hA00 + 32'(k)});
        for (int k = 0; k < 4; k++) s1.push_back('{5'(16 + k), 32'hB00 + 32'(k)});
        run();
        repeat (6) @(negedge clk);
        chk("bp_saw_full", saw_full, 1);
        foreach (log_q[k]) if (log_q[k] >= 16) got.push_back(log_q[k]);
        chk("bp_req1_len", got.size(), 4);
        for (int k = 0; k < 4 && k < got.size(); k++) chk($sformatf("bp_req1_order%0d", k), got[k], 16 + k);
        chk("bp_total", log_q.size(), 10);

        @(negedge clk);
        req1_valid = 1'b1; req1_reg = 5'd0; req1_data = 32'hFFFF0000;
        @(negedge clk);
        req1_valid = 1'b0;
        chk("r0_we", reg_write, 0);
        chk("r0_data", write_data, 32'hFFFF0000);
        chk("r0_mask", pending_mask, 0);
        chk("r0_count", write_count, 16);
        chk("r0_count4", w_count, 0);

        do_reset();
        for (int k = 0; k < 17; k++) s0.push_back('{5'(k % 31 + 1), 32'(k)});
        run();
        repeat (2) @(negedge clk);
        chk("wrap_count4", w_count, 1);
        chk("wrap_count16", write_count, 17);

        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            req0_valid = 1'b1; req0_reg = 5'(20 + k); req0_data = 32'hC0 + 32'(k);
            req1_valid = 1'b1; req1_reg = 5'(24 + k); req1_data = 32'hD0 + 32'(k);
        end
        @(posedge clk);
        #1;
        chk("pre_reset_busy", reg_write, 1);
        #1;
        rst = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #1;
        chk("async_rst_we", reg_write, 0);
        chk("async_rst_mask", pending_mask, 0);
        chk("async_rst_ready0", req0_ready, 1);
        chk("async_rst_ready1", req1_ready, 1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        log_q.delete();
        repeat (5) @(negedge clk);
        chk("no_write_after_reset", log_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
